// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and writeback channels between decode, the shared ALU and the register file.
// slave = issue controller view, master = environment view.
interface alu_issue_ctrl_if #(
   parameter int RD_W   = 4,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_cond;
   logic [4:0]        req_op;
   logic              req_s;
   logic [RD_W-1:0]   req_rd;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;

   logic [3:0]        alu_cond;
   logic [DATA_W-1:0] alu_data1;
   logic [DATA_W-1:0] alu_data2;
   logic [4:0]        alu_operation;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;

   logic              wb_valid;
   logic              wb_ready;
   logic [RD_W-1:0]   wb_rd;
   logic [DATA_W-1:0] wb_data;

   modport slave (
      input  req_valid, req_cond, req_op, req_s, req_rd, req_a, req_b,
      output req_ready,
      output alu_cond, alu_data1, alu_data2, alu_operation,
      input  alu_result, alu_flags,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready
   );

   modport master (
      output req_valid, req_cond, req_op, req_s, req_rd, req_a, req_b,
      input  req_ready,
      input  alu_cond, alu_data1, alu_data2, alu_operation,
      output alu_result, alu_flags,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared ALU: condition check against NZCV, flag ownership, writeback handshake.
// Optional performance counters enabled by defining ALU_ISSUE_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | ready for an instruction; operands latched on accept
// EXEC  | ALU evaluates latched operands, condition checked against cpsr
// WB    | result offered to register file until wb_ready
module alu_issue_ctrl #(
   parameter int RD_W   = 4,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   alu_issue_ctrl_if.slave bus,
   output logic [3:0]  cpsr,
   input  logic        flag_wr,
   input  logic [3:0]  flag_wr_data,
   output logic        exec_done,
   output logic        exec_skipped
`ifdef ALU_ISSUE_CTRL_PERF_EN
  ,output logic [31:0] perf_exec,
   output logic [31:0] perf_skip,
   output logic [31:0] perf_wbstall
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cond_q, cond_d;
   logic [4:0]        op_q, op_d;
   logic              s_q, s_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [3:0]        cpsr_q, cpsr_d;
   logic              exec_done_q, exec_done_d;
   logic              exec_skipped_q, exec_skipped_d;
   logic              is_cmp;
   logic              pass;

   // cpsr packing: [0]=Z [1]=C [2]=N [3]=V
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic z, cf, n, v;
      z  = f[0];
      cf = f[1];
      n  = f[2];
      v  = f[3];
      case (c)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = !z;
         4'b0010: cond_pass = cf;
         4'b0011: cond_pass = !cf;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = !n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = !v;
         4'b1000: cond_pass = cf && !z;
         4'b1001: cond_pass = !cf || z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = !z && (n == v);
         4'b1101: cond_pass = z || (n != v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign is_cmp = (op_q[4:2] == 3'b010);
   assign pass   = cond_pass(cond_q, cpsr_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.req_valid) state_d = S_EXEC;
         S_EXEC:  state_d = (pass && !is_cmp) ? S_WB : S_IDLE;
         S_WB:    if (bus.wb_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == S_IDLE);
      bus.wb_valid  = (state_q == S_WB);
   end

   always_comb begin
      cond_d         = cond_q;
      op_d           = op_q;
      s_d            = s_q;
      rd_d           = rd_q;
      a_d            = a_q;
      b_d            = b_q;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      cpsr_d         = cpsr_q;
      exec_done_d    = (state_q == S_EXEC);
      exec_skipped_d = (state_q == S_EXEC) && !pass;
      if (state_q == S_IDLE && bus.req_valid) begin
         cond_d = bus.req_cond;
         op_d   = bus.req_op;
         s_d    = bus.req_s;
         rd_d   = bus.req_rd;
         a_d    = bus.req_a;
         b_d    = bus.req_b;
      end
      if (state_q == S_EXEC && pass) begin
         wb_data_d = bus.alu_result;
         wb_rd_d   = rd_q;
         // ALU carry is not trusted; C only changes through flag_wr
         if (s_q || is_cmp)
            cpsr_d = {bus.alu_flags[3], bus.alu_flags[2], cpsr_q[1], bus.alu_flags[0]};
      end
      if (flag_wr) cpsr_d = flag_wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cond_q         <= '0;
         op_q           <= '0;
         s_q            <= 1'b0;
         rd_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         cpsr_q         <= '0;
         exec_done_q    <= 1'b0;
         exec_skipped_q <= 1'b0;
      end else begin
         cond_q         <= cond_d;
         op_q           <= op_d;
         s_q            <= s_d;
         rd_q           <= rd_d;
         a_q            <= a_d;
         b_q            <= b_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         cpsr_q         <= cpsr_d;
         exec_done_q    <= exec_done_d;
         exec_skipped_q <= exec_skipped_d;
      end
   end

   assign bus.alu_cond      = cond_q;
   assign bus.alu_operation = op_q;
   assign bus.alu_data1     = a_q;
   assign bus.alu_data2     = b_q;
   assign bus.wb_rd         = wb_rd_q;
   assign bus.wb_data       = wb_data_q;
   assign cpsr              = cpsr_q;
   assign exec_done         = exec_done_q;
   assign exec_skipped      = exec_skipped_q;

`ifdef ALU_ISSUE_CTRL_PERF_EN
   logic [31:0] perf_exec_q, perf_exec_d;
   logic [31:0] perf_skip_q, perf_skip_d;
   logic [31:0] perf_wbstall_q, perf_wbstall_d;

   always_comb begin
      perf_exec_d    = perf_exec_q + {31'd0, exec_done_q};
      perf_skip_d    = perf_skip_q + {31'd0, exec_done_q && exec_skipped_q};
      perf_wbstall_d = perf_wbstall_q + {31'd0, bus.wb_valid && !bus.wb_ready};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_exec_q    <= '0;
         perf_skip_q    <= '0;
         perf_wbstall_q <= '0;
      end else begin
         perf_exec_q    <= perf_exec_d;
         perf_skip_q    <= perf_skip_d;
         perf_wbstall_q <= perf_wbstall_d;
      end
   end

   assign perf_exec    = perf_exec_q;
   assign perf_skip    = perf_skip_q;
   assign perf_wbstall = perf_wbstall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU whose carry output is deliberately always 1.
module tb_alu_issue_ctrl;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00100;
   localparam logic [4:0] OP_CMP = 5'b01010;
   localparam logic [4:0] OP_CMN = 5'b01011;

   logic       clk;
   logic       reset;
   logic [3:0] cpsr;
   logic       flag_wr;
   logic [3:0] flag_wr_data;
   logic       exec_done;
   logic       exec_skipped;
   int         total;
   int         bad;
`ifdef ALU_ISSUE_CTRL_PERF_EN
   logic [31:0] perf_exec, perf_skip, perf_wbstall;
`endif

   alu_issue_ctrl_if #(.RD_W(4), .DATA_W(32)) bus ();

   alu_issue_ctrl #(.RD_W(4), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .cpsr         (cpsr),
      .flag_wr      (flag_wr),
      .flag_wr_data (flag_wr_data),
      .exec_done    (exec_done),
      .exec_skipped (exec_skipped)
`ifdef ALU_ISSUE_CTRL_PERF_EN
     ,.perf_exec    (perf_exec),
      .perf_skip    (perf_skip),
      .perf_wbstall (perf_wbstall)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALU; flags {V,N,C,Z} with C forced to 1
   always_comb begin
      logic [31:0] r;
      logic        v;
      r = 32'd0;
      v = 1'b0;
      case (bus.alu_operation)
         OP_ADD, OP_CMN: begin
            r = bus.alu_data1 + bus.alu_data2;
            v = (bus.alu_data1[31] == bus.alu_data2[31]) && (r[31] != bus.alu_data1[31]);
         end
         OP_SUB, OP_CMP: begin
            r = bus.alu_data1 - bus.alu_data2;
            v = (bus.alu_data1[31] != bus.alu_data2[31]) && (r[31] != bus.alu_data1[31]);
         end
         default: begin
            r = 32'd0;
            v = 1'b0;
         end
      endcase
      bus.alu_result = r;
      bus.alu_flags  = {v, r[31], 1'b1, (r == 32'd0)};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one request for a single edge; returns during the EXEC cycle
   task automatic issue(input logic [3:0] c, input logic [4:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid = 1'b1;
      bus.req_cond  = c;
      bus.req_op    = op;
      bus.req_s     = s;
      bus.req_rd    = rd;
      bus.req_a     = a;
      bus.req_b     = b;
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic write_flags(input logic [3:0] f);
      flag_wr      = 1'b1;
      flag_wr_data = f;
      step();
      flag_wr      = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b0;
      flag_wr       = 1'b0;
      flag_wr_data  = 4'd0;
      bus.req_valid = 1'b0;
      bus.req_cond  = 4'd0;
      bus.req_op    = 5'd0;
      bus.req_s     = 1'b0;
      bus.req_rd    = 4'd0;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.wb_ready  = 1'b1;

      step();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_cpsr", cpsr, 0);
      chk("rst_alu_data1", bus.alu_data1, 0);
      chk("rst_exec_done", exec_done, 0);
      reset = 1'b1;
      step();

      // ADD, always, s=1
      issue(4'b1110, OP_ADD, 1'b1, 4'd5, 32'd3, 32'd7);
      chk("add_exec_req_ready", bus.req_ready, 0);
      chk("add_exec_wb_valid", bus.wb_valid, 0);
      chk("add_exec_alu_data1", bus.alu_data1, 3);
      chk("add_exec_alu_op", bus.alu_operation, OP_ADD);
      step();
      chk("add_wb_valid", bus.wb_valid, 1);
      chk("add_wb_data", bus.wb_data, 10);
      chk("add_wb_rd", bus.wb_rd, 5);
      chk("add_cpsr", cpsr, 4'b0000);
      chk("add_exec_done", exec_done, 1);
      chk("add_exec_skipped", exec_skipped, 0);
      step();
      chk("add_after_wb_valid", bus.wb_valid, 0);
      chk("add_after_exec_done", exec_done, 0);
      chk("add_after_req_ready", bus.req_ready, 1);

      // Z=1 then SUB NE (skip) and SUB EQ (executes)
      write_flags(4'b0001);
      chk("fw_cpsr", cpsr, 4'b0001);
      issue(4'b0001, OP_SUB, 1'b0, 4'd2, 32'd9, 32'd9);
      step();
      chk("ne_wb_valid", bus.wb_valid, 0);
      chk("ne_exec_done", exec_done, 1);
      chk("ne_exec_skipped", exec_skipped, 1);
      chk("ne_cpsr", cpsr, 4'b0001);
      chk("ne_req_ready", bus.req_ready, 1);
      issue(4'b0000, OP_SUB, 1'b0, 4'd2, 32'd9, 32'd9);
      step();
      chk("eq_wb_valid", bus.wb_valid, 1);
      chk("eq_wb_data", bus.wb_data, 0);
      chk("eq_exec_skipped", exec_skipped, 0);
      step();

      // CMP with s=0 still sets flags; C preserved
      write_flags(4'b0000);
      issue(4'b1110, OP_CMP, 1'b0, 4'd8, 32'd5, 32'd5);
      step();
      chk("cmp_wb_valid", bus.wb_valid, 0);
      chk("cmp_cpsr", cpsr, 4'b0001);
      chk("cmp_exec_done", exec_done, 1);
      chk("cmp_req_ready", bus.req_ready, 1);
      issue(4'b0000, OP_ADD, 1'b0, 4'd3, 32'd1, 32'd2);
      step();
      chk("cmp_then_add_wb_valid", bus.wb_valid, 1);
      chk("cmp_then_add_wb_data", bus.wb_data, 3);
      step();

      // Writeback stall with a competing request held
      bus.wb_ready = 1'b0;
      issue(4'b1110, OP_ADD, 1'b0, 4'd7, 32'd100, 32'd23);
      step();
      bus.req_valid = 1'b1;
      bus.req_cond  = 4'b1110;
      bus.req_op    = OP_ADD;
      bus.req_s     = 1'b0;
      bus.req_rd    = 4'd1;
      bus.req_a     = 32'd1;
      bus.req_b     = 32'd1;
      for (int i = 0; i < 4; i++) begin
         chk("stall_wb_valid", bus.wb_valid, 1);
         chk("stall_wb_data", bus.wb_data, 123);
         chk("stall_wb_rd", bus.wb_rd, 7);
         chk("stall_req_ready", bus.req_ready, 0);
         step();
      end
`ifdef ALU_ISSUE_CTRL_PERF_EN
      chk("perf_wbstall", perf_wbstall, 4);
`endif
      chk("stall_end_wb_valid", bus.wb_valid, 1);
      bus.wb_ready = 1'b1;
      step();
      chk("hs_wb_valid", bus.wb_valid, 0);
      chk("hs_req_ready", bus.req_ready, 1);
      chk("hs_alu_data1_held", bus.alu_data1, 100);
      step();
      bus.req_valid = 1'b0;
      chk("next_exec_req_ready", bus.req_ready, 0);
      chk("next_exec_alu_data1", bus.alu_data1, 1);
      step();
      chk("next_wb_data", bus.wb_data, 2);
      chk("next_wb_rd", bus.wb_rd, 1);
      step();

      // Reset during EXEC
      write_flags(4'b1111);
      issue(4'b1110, OP_ADD, 1'b0, 4'd9, 32'd4, 32'd4);
      #2 reset = 1'b0;
      #1;
      chk("rexec_req_ready", bus.req_ready, 1);
      chk("rexec_wb_valid", bus.wb_valid, 0);
      chk("rexec_cpsr", cpsr, 0);
      chk("rexec_alu_data1", bus.alu_data1, 0);
      chk("rexec_alu_op", bus.alu_operation, 0);
      #2 reset = 1'b1;
      step();
      chk("rexec_after_wb_valid", bus.wb_valid, 0);
      chk("rexec_after_exec_done", exec_done, 0);
      step();
      chk("rexec_after2_wb_valid", bus.wb_valid, 0);

      // Reset during WB
      bus.wb_ready = 1'b0;
      issue(4'b1110, OP_ADD, 1'b0, 4'd4, 32'd6, 32'd6);
      step();
      chk("rwb_pre_wb_valid", bus.wb_valid, 1);
      chk("rwb_pre_wb_data", bus.wb_data, 12);
      #2 reset = 1'b0;
      #1;
      chk("rwb_wb_valid", bus.wb_valid, 0);
      chk("rwb_wb_data", bus.wb_data, 0);
      chk("rwb_wb_rd", bus.wb_rd, 0);
      chk("rwb_req_ready", bus.req_ready, 1);
      #2 reset = 1'b1;
      bus.wb_ready = 1'b1;
      step();
      chk("rwb_after_wb_valid", bus.wb_valid, 0);
      step();
      chk("rwb_after2_wb_valid", bus.wb_valid, 0);
      chk("rwb_after2_exec_done", exec_done, 0);

      // flag_wr collides with CMN flag update
      issue(4'b1110, OP_CMN, 1'b1, 4'd0, 32'd1, 32'd1);
      flag_wr      = 1'b1;
      flag_wr_data = 4'b1010;
      step();
      flag_wr = 1'b0;
      chk("cmn_fw_cpsr", cpsr, 4'b1010);
      chk("cmn_fw_wb_valid", bus.wb_valid, 0);
      chk("cmn_fw_exec_done", exec_done, 1);
      chk("cmn_fw_exec_skipped", exec_skipped, 0);

      // Signed conditions with N=0 V=1, and the reserved never code
      issue(4'b1011, OP_ADD, 1'b0, 4'd6, 32'd2, 32'd2);
      step();
      chk("lt_wb_valid", bus.wb_valid, 1);
      chk("lt_wb_data", bus.wb_data, 4);
      step();
      issue(4'b1010, OP_ADD, 1'b0, 4'd6, 32'd2, 32'd2);
      step();
      chk("ge_exec_skipped", exec_skipped, 1);
      chk("ge_wb_valid", bus.wb_valid, 0);
      issue(4'b1111, OP_ADD, 1'b0, 4'd6, 32'd2, 32'd2);
      step();
      chk("nv_exec_skipped", exec_skipped, 1);
      chk("nv_wb_valid", bus.wb_valid, 0);
      chk("nv_cpsr", cpsr, 4'b1010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
